snax_csr_responder: RTL and testbench
=====================================

# snax_csr_responder

Accelerator-side end of the SNAX CSR request/response interface: accepts core CSR requests (address, data, write-enable, valid/ready), stores configuration registers, launches the accelerator, and returns read data over a registered valid/ready response channel. It sits behind the CSR demux, one instance per accelerator port, and drives the accelerator's configuration, start and status signals.

## Interface
- RegDataWidth, 32, CSR data width
- RegAddrWidth, 32, CSR address width
- NumRwCsr, 4, number of read/write configuration registers (≥1)
- NumRoCsr, 2, number of read-only accelerator status inputs (≥0)

- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- csr_req_addr_i  in  RegAddrWidth  request address (word index)
- csr_req_data_i  in  RegDataWidth  write data
- csr_req_wen_i  in  1  1 = write, 0 = read
- csr_req_valid_i  in  1  request valid
- csr_req_ready_o  out  1  request accepted this cycle when high with valid
- csr_rsp_data_o  out  RegDataWidth  read data
- csr_rsp_valid_o  out  1  read response valid
- csr_rsp_ready_i  in  1  core accepts response
- rw_csr_o  out  NumRwCsr×RegDataWidth  configuration register contents
- ro_csr_i  in  NumRoCsr×RegDataWidth  accelerator read-only values
- acc_start_o  out  1  one-cycle launch pulse
- acc_done_i  in  1  one-cycle completion pulse from accelerator

## Operation
- Address map (A = NumRwCsr): 0..A-1 RW config; A = START (write-only, reads 0); A+1 = STATUS (bit0 busy, bit1 done, rest 0); A+2 = PERF (cycle counter, RO); A+3..A+2+NumRoCsr = ro_csr_i. All other addresses: writes dropped, reads return 0.
- FSM states IDLE, LAUNCH, BUSY. IDLE→LAUNCH on accepted write to START with data bit0=1. LAUNCH→BUSY unconditionally (acc_start_o=1 only in LAUNCH). BUSY→IDLE on acc_done_i. acc_done_i outside BUSY ignored. START writes outside IDLE, or with bit0=0, are accepted and discarded.
- busy = (state != IDLE). done bit: cleared on entering LAUNCH, set on BUSY→IDLE, sticky otherwise.
- PERF: cleared to 0 on entering LAUNCH; increments each cycle in LAUNCH or BUSY; saturates at all-ones; holds in IDLE.
- Config writes while busy are stalled: csr_req_ready_o=0 for a valid write to 0..A-1 while busy; accepted the cycle after return to IDLE.
- Reads produce exactly one response; writes produce none.
- One-entry response register. csr_req_ready_o = ¬stall_cfg ∧ (¬csr_rsp_valid_o ∨ csr_rsp_ready_i). Same rule applies to writes (requests strictly in order).

## Timing
- Reset: rw_csr_o=0, csr_rsp_data_o=0, csr_rsp_valid_o=0, acc_start_o=0, state IDLE, PERF=0, done=0. csr_req_ready_o is combinational; =1 after reset (no response pending, idle).
- Write: register updated at accepting edge; visible on rw_csr_o next cycle.
- Read: data sampled at accepting edge, csr_rsp_valid_o high next cycle; data and valid held stable until csr_rsp_ready_i.
- Response handshake and new read accepted in same cycle → back-to-back reads at one per cycle.
- Read accepted in the cycle after a write to the same register returns new value.
- START write accepted at edge t → acc_start_o high cycle t+1, STATUS.busy reads 1 for reads accepted from t+1.
- acc_done_i at edge t in BUSY → IDLE at t+1; stalled config write accepted at t+1.
- Reset mid-operation: immediate return to reset values; pending response discarded.

## Test plan
- Reset, write 0xDEADBEEF to addr 1, read addr 1 → rw_csr_o[1]=0xDEADBEEF next cycle, rsp 0xDEADBEEF one cycle after read acceptance.
- Hold csr_rsp_ready_i=0 with read pending, present second read → csr_req_ready_o=0, rsp data stable; release → one rsp per cycle, in order.
- Write 1 to addr 4 (START), hold acc_done_i 0 for 10 cycles, pulse → acc_start_o single pulse; STATUS reads 0x1 while busy, 0x2 after; PERF reads 11.
- While BUSY, write addr 0 → ready low until cycle after acc_done_i, then rw_csr_o[0] updates; read addr 1 during BUSY → served immediately.
- Write START while BUSY, write START data 0 in IDLE → no acc_start_o; read addr 100 → 0; write addr 100 → no state change.
- Assert rst_i in BUSY with response pending → all outputs reset same cycle, csr_rsp_valid_o=0, ro_csr_i[0]=0x55 readable at addr 7 afterwards.

Source files
------------

// File: rtl/snax_csr_responder.sv
// snax_csr_responder: accelerator-side end of the SNAX CSR request/response port.
// Holds the RW configuration registers, launches the accelerator through a small
// IDLE/LAUNCH/BUSY FSM, tracks a sticky done flag and a run-cycle counter, and
// returns read data through a one-entry registered response slot.
module snax_csr_responder #(
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned RegAddrWidth = 32,
  parameter int unsigned NumRwCsr     = 4,
  parameter int unsigned NumRoCsr     = 2
) (
  input  logic                                                    clk_i,
  input  logic                                                    rst_i,
  input  logic [RegAddrWidth-1:0]                                 csr_req_addr_i,
  input  logic [RegDataWidth-1:0]                                 csr_req_data_i,
  input  logic                                                    csr_req_wen_i,
  input  logic                                                    csr_req_valid_i,
  output logic                                                    csr_req_ready_o,
  output logic [RegDataWidth-1:0]                                 csr_rsp_data_o,
  output logic                                                    csr_rsp_valid_o,
  input  logic                                                    csr_rsp_ready_i,
  output logic [NumRwCsr-1:0][RegDataWidth-1:0]                   rw_csr_o,
  input  logic [((NumRoCsr > 0) ? NumRoCsr : 1)-1:0][RegDataWidth-1:0] ro_csr_i,
  output logic                                                    acc_start_o,
  input  logic                                                    acc_done_i
);

  // Address map: config registers first, then the control/status words, then
  // the accelerator's read-only values.
  localparam logic [RegAddrWidth-1:0] AddrStart  = RegAddrWidth'(NumRwCsr);
  localparam logic [RegAddrWidth-1:0] AddrStatus = RegAddrWidth'(NumRwCsr + 1);
  localparam logic [RegAddrWidth-1:0] AddrPerf   = RegAddrWidth'(NumRwCsr + 2);
  localparam logic [RegAddrWidth-1:0] AddrRoBase = RegAddrWidth'(NumRwCsr + 3);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLaunch = 2'd1,
    StBusy   = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    done_q;
  logic                    acc_start_q;
  logic [RegDataWidth-1:0] perf_q;
  logic [RegDataWidth-1:0] perf_d;
  logic                    rsp_valid_q;
  logic [RegDataWidth-1:0] rsp_data_q;
  logic [RegDataWidth-1:0] rw_q [NumRwCsr];
  logic [RegDataWidth-1:0] rd_data;

  logic busy;
  logic is_cfg_addr;
  logic stall_cfg;
  logic req_accept;
  logic wr_accept;
  logic rd_accept;
  logic start_req;

  assign busy        = (state_q != StIdle);
  assign is_cfg_addr = (csr_req_addr_i < AddrStart);
  // Config registers must not change under a running accelerator, so such
  // writes wait; everything else keeps flowing.
  assign stall_cfg   = csr_req_valid_i & csr_req_wen_i & is_cfg_addr & busy;
  // A new request may only be taken when the response slot is free or drains now.
  assign csr_req_ready_o = ~stall_cfg & (~rsp_valid_q | csr_rsp_ready_i);

  assign req_accept = csr_req_valid_i & csr_req_ready_o;
  assign wr_accept  = req_accept & csr_req_wen_i;
  assign rd_accept  = req_accept & ~csr_req_wen_i;
  // START only launches from IDLE with bit0 set; any other START write is dropped.
  assign start_req  = wr_accept & (csr_req_addr_i == AddrStart) &
                      csr_req_data_i[0] & (state_q == StIdle);

  // Saturating increment of the run-cycle counter.
  assign perf_d = (&perf_q) ? perf_q : perf_q + 1'b1;

  // Configuration registers: one register per generate slot, written on accept.
  for (genvar gi = 0; gi < NumRwCsr; gi++) begin : g_rw
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rw_q[gi] <= '0;
      end else if (wr_accept && (csr_req_addr_i == RegAddrWidth'(gi))) begin
        rw_q[gi] <= csr_req_data_i;
      end
    end
    assign rw_csr_o[gi] = rw_q[gi];
  end

  // Read-data mux over the whole address map; unmapped addresses read zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(NumRwCsr); i++) begin
      if (csr_req_addr_i == RegAddrWidth'(i)) rd_data = rw_q[i];
    end
    if (csr_req_addr_i == AddrStatus) begin
      rd_data = {{(RegDataWidth-2){1'b0}}, done_q, busy};
    end
    if (csr_req_addr_i == AddrPerf) rd_data = perf_q;
    for (int j = 0; j < int'(NumRoCsr); j++) begin
      if (csr_req_addr_i == AddrRoBase + RegAddrWidth'(j)) rd_data = ro_csr_i[j];
    end
  end

  // Launch FSM with registered start pulse, sticky done flag and cycle counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      acc_start_q <= 1'b0;
      done_q      <= 1'b0;
      perf_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          acc_start_q <= 1'b0;
          if (start_req) begin
            state_q     <= StLaunch;
            acc_start_q <= 1'b1;
            done_q      <= 1'b0;
            perf_q      <= '0;
          end
        end
        StLaunch: begin
          state_q     <= StBusy;
          acc_start_q <= 1'b0;
          perf_q      <= perf_d;
        end
        StBusy: begin
          acc_start_q <= 1'b0;
          perf_q      <= perf_d;
          if (acc_done_i) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          acc_start_q <= 1'b0;
        end
      endcase
    end
  end

  // One-entry response slot: loaded by a read accept, cleared when drained.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else if (rd_accept) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= rd_data;
    end else if (csr_rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign csr_rsp_valid_o = rsp_valid_q;
  assign csr_rsp_data_o  = rsp_data_q;
  assign acc_start_o     = acc_start_q;

endmodule

// File: tb/tb_snax_csr_responder.sv
// Testbench for snax_csr_responder: table of single transactions, hand-written
// multi-cycle sequences, then randomized traffic against a behavioural model.
module tb_snax_csr_responder;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int NRW = 4;
  localparam int NRO = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [AW-1:0]           addr;
  logic [DW-1:0]           data;
  logic                    wen;
  logic                    valid;
  logic                    ready;
  logic [DW-1:0]           rsp_data;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [NRW-1:0][DW-1:0]  rw_csr;
  logic [NRO-1:0][DW-1:0]  ro_csr;
  logic                    acc_start;
  logic                    acc_done;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;

  snax_csr_responder #(
    .RegDataWidth(DW), .RegAddrWidth(AW), .NumRwCsr(NRW), .NumRoCsr(NRO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .csr_req_addr_i (addr),
    .csr_req_data_i (data),
    .csr_req_wen_i  (wen),
    .csr_req_valid_i(valid),
    .csr_req_ready_o(ready),
    .csr_rsp_data_o (rsp_data),
    .csr_rsp_valid_o(rsp_valid),
    .csr_rsp_ready_i(rsp_ready),
    .rw_csr_o       (rw_csr),
    .ro_csr_i       (ro_csr),
    .acc_start_o    (acc_start),
    .acc_done_i     (acc_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (acc_start === 1'b1) start_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Wait (bounded) until the current request is accepted; returns #1 after the edge.
  task automatic wait_accept();
    bit done_w = 0;
    for (int n = 0; n < 50 && !done_w; n++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        @(posedge clk);
        #1;
        done_w = 1;
      end
    end
    if (!done_w) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no_accept want accept addr=%0d", addr);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; data = d; wen = 1'b1; valid = 1'b1;
    wait_accept();
    valid = 1'b0; wen = 1'b0;
    $display("write addr=%0d data=%h", a, d);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    rsp_ready = 1'b1; addr = a; wen = 1'b0; valid = 1'b1;
    wait_accept();
    valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk(name, rsp_data, exp);
    $display("read  addr=%0d data=%h exp=%h", a, rsp_data, exp);
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_rw [NRW];
  bit          m_running;
  int          m_runcyc;
  bit          m_done;
  logic [31:0] m_perf;
  bit          m_rspv;
  logic [31:0] m_rspd;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a < NRW)         return m_rw[a];
    if (a == NRW + 1)    return {30'b0, m_done, m_running};
    if (a == NRW + 2)    return m_perf;
    if (a == NRW + 3)    return ro_csr[0];
    if (a == NRW + 4)    return ro_csr[1];
    return 32'h0;
  endfunction

  typedef struct {
    bit          is_wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[15];
  logic [31:0] exp_rw [NRW];

  initial begin
    rst = 1'b1; addr = '0; data = '0; wen = 1'b0; valid = 1'b0;
    rsp_ready = 1'b1; acc_done = 1'b0;
    ro_csr[0] = 32'h55; ro_csr[1] = 32'hA5A50001;

    vt[0]  = '{1'b1, 32'd1,   32'hDEADBEEF, 32'h0};
    vt[1]  = '{1'b0, 32'd1,   32'h0,        32'hDEADBEEF};
    vt[2]  = '{1'b1, 32'd0,   32'h11111111, 32'h0};
    vt[3]  = '{1'b1, 32'd3,   32'hCAFEF00D, 32'h0};
    vt[4]  = '{1'b0, 32'd0,   32'h0,        32'h11111111};
    vt[5]  = '{1'b0, 32'd3,   32'h0,        32'hCAFEF00D};
    vt[6]  = '{1'b0, 32'd2,   32'h0,        32'h0};
    vt[7]  = '{1'b0, 32'd4,   32'h0,        32'h0};
    vt[8]  = '{1'b0, 32'd5,   32'h0,        32'h0};
    vt[9]  = '{1'b0, 32'd6,   32'h0,        32'h0};
    vt[10] = '{1'b0, 32'd7,   32'h0,        32'h55};
    vt[11] = '{1'b0, 32'd8,   32'h0,        32'hA5A50001};
    vt[12] = '{1'b1, 32'd100, 32'h12345678, 32'h0};
    vt[13] = '{1'b0, 32'd100, 32'h0,        32'h0};
    vt[14] = '{1'b0, 32'd9,   32'h0,        32'h0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_acc_start", {31'b0, acc_start}, 32'd0);
    for (int i = 0; i < NRW; i++) chk("rst_rw", rw_csr[i], 32'd0);
    @(posedge clk); #1;

    // Table-driven single transactions
    for (int k = 0; k < 15; k++) begin
      if (vt[k].is_wr) begin
        do_write(vt[k].a, vt[k].d);
        if (vt[k].a < NRW) chk("vec_rw_csr", rw_csr[vt[k].a], vt[k].d);
      end else begin
        do_read(vt[k].a, vt[k].exp, "vec_read");
      end
    end

    // Back-pressure: pending response blocks the next read, data stays stable
    rsp_ready = 1'b0; addr = 32'd0; wen = 1'b0; valid = 1'b1;
    wait_accept();
    addr = 32'd3;
    @(negedge clk);
    chk("bp_ready_low", {31'b0, ready}, 32'd0);
    chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("bp_rsp_data", rsp_data, 32'h11111111);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_hold_ready", {31'b0, ready}, 32'd0);
      chk("bp_hold_data", rsp_data, 32'h11111111);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'b0, ready}, 32'd1);
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", {31'b0, rsp_valid}, 32'd1);
    chk("bp_second_data", rsp_data, 32'hCAFEF00D);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_drained", {31'b0, rsp_valid}, 32'd0);
    $display("backpressure sequence done");
    @(posedge clk); #1;

    // Launch, 10 idle cycles then done pulse; PERF must read 11
    begin
      int s0;
      s0 = start_cnt;
      acc_done = 1'b0;
      addr = 32'd4; data = 32'd1; wen = 1'b1; valid = 1'b1;
      wait_accept();
      addr = 32'd5; wen = 1'b0; valid = 1'b1; rsp_ready = 1'b1;
      @(negedge clk);
      chk("launch_start_hi", {31'b0, acc_start}, 32'd1);
      @(posedge clk); #1;
      valid = 1'b0;
      @(negedge clk);
      chk("launch_start_lo", {31'b0, acc_start}, 32'd0);
      chk("launch_status_busy", rsp_data, 32'h1);
      repeat (9) @(posedge clk);
      #1 acc_done = 1'b1;
      @(posedge clk);
      #1 acc_done = 1'b0;
      chk("launch_pulses", start_cnt - s0, 32'd1);
      do_read(32'd5, 32'h2, "status_done");
      do_read(32'd6, 32'd11, "perf_count");
    end

    // Config write stalled while busy; reads still served
    do_write(32'd4, 32'd1);
    do_read(32'd5, 32'h1, "stall_status");
    do_read(32'd1, 32'hDEADBEEF, "busy_read");
    addr = 32'd0; data = 32'h00001234; wen = 1'b1; valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_ready_low", {31'b0, ready}, 32'd0);
      chk("stall_rw_hold", rw_csr[0], 32'h11111111);
      @(posedge clk); #1;
    end
    acc_done = 1'b1;
    @(negedge clk);
    chk("stall_done_cycle", {31'b0, ready}, 32'd0);
    @(posedge clk); #1;
    acc_done = 1'b0;
    @(negedge clk);
    chk("stall_release", {31'b0, ready}, 32'd1);
    @(posedge clk); #1;
    valid = 1'b0; wen = 1'b0;
    chk("stall_rw_update", rw_csr[0], 32'h00001234);
    $display("stall sequence done");

    // START while busy and START with bit0=0 are discarded; unmapped access
    begin
      int s0;
      s0 = start_cnt;
      do_write(32'd4, 32'd1);
      do_write(32'd4, 32'd1);
      do_write(32'd4, 32'd3);
      acc_done = 1'b1;
      @(posedge clk); #1;
      acc_done = 1'b0;
      do_write(32'd4, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("start_discard", start_cnt - s0, 32'd1);
      do_read(32'd5, 32'h2, "discard_status");
      do_write(32'd100, 32'hFFFFFFFF);
      exp_rw[0] = 32'h00001234; exp_rw[1] = 32'hDEADBEEF;
      exp_rw[2] = 32'h0;        exp_rw[3] = 32'hCAFEF00D;
      for (int i = 0; i < NRW; i++) chk("unmapped_write", rw_csr[i], exp_rw[i]);
      do_read(32'd100, 32'h0, "unmapped_read");
    end

    // Reset while busy with a response pending
    do_write(32'd4, 32'd1);
    rsp_ready = 1'b0; addr = 32'd6; wen = 1'b0; valid = 1'b1;
    wait_accept();
    valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_pending", {31'b0, rsp_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_rsp_data", rsp_data, 32'd0);
    chk("mid_rst_start", {31'b0, acc_start}, 32'd0);
    for (int i = 0; i < NRW; i++) chk("mid_rst_rw", rw_csr[i], 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready = 1'b1;
    do_read(32'd7, 32'h55, "post_rst_ro0");
    do_read(32'd5, 32'h0, "post_rst_status");
    do_read(32'd6, 32'h0, "post_rst_perf");

    // Randomized traffic against the model
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NRW; i++) m_rw[i] = 32'h0;
    m_running = 0; m_runcyc = 0; m_done = 0; m_perf = 32'h0;
    m_rspv = 0; m_rspd = 32'h0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int a;
      bit exp_ready;
      bit acc;
      bit exp_start;
      logic [31:0] rdv;
      valid = ($urandom_range(0, 3) != 0);
      wen = $urandom_range(0, 1);
      a = $urandom_range(0, 9);
      addr = (a == 9) ? 32'd100 : 32'(a);
      data = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      acc_done = ($urandom_range(0, 7) == 0);
      ro_csr[0] = $urandom;
      ro_csr[1] = $urandom;
      exp_ready = !(valid && wen && (addr < NRW) && m_running) && (!m_rspv || rsp_ready);
      exp_start = m_running && (m_runcyc == 0);
      @(negedge clk);
      chk("rnd_ready", {31'b0, ready}, {31'b0, exp_ready});
      chk("rnd_rsp_valid", {31'b0, rsp_valid}, {31'b0, m_rspv});
      if (m_rspv) chk("rnd_rsp_data", rsp_data, m_rspd);
      chk("rnd_acc_start", {31'b0, acc_start}, {31'b0, exp_start});
      for (int i = 0; i < NRW; i++) chk("rnd_rw", rw_csr[i], m_rw[i]);
      @(posedge clk);
      acc = valid && exp_ready;
      rdv = model_read(addr);
      if (acc && !wen) begin
        m_rspv = 1; m_rspd = rdv;
      end else if (rsp_ready) begin
        m_rspv = 0;
      end
      if (acc && wen && addr < NRW) m_rw[addr] = data;
      if (m_running) begin
        if (m_perf != 32'hFFFFFFFF) m_perf = m_perf + 1;
        if (m_runcyc > 0 && acc_done) begin
          m_running = 0;
          m_done = 1;
        end
        m_runcyc++;
      end else if (acc && wen && addr == NRW && data[0]) begin
        m_running = 1; m_runcyc = 0; m_done = 0; m_perf = 32'h0;
      end
      #1;
    end
    $display("random phase done: cycles=2000");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
